// File: rtl/sy_alu_pkg.sv
// rtl/sy_alu_pkg.sv - shared datapath constants and FSM state encoding for sy_alu_ctrl
package sy_alu_pkg;

   localparam int SY_WIDTH = 16;
   localparam int SY_OPCW  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      DONE  = 2'd2,
      EXEC2 = 2'd3
   } state_t;

endpackage

// File: rtl/sy_alu_opreg.sv
// rtl/sy_alu_opreg.sv - operand/opcode register bank driving the SY_ALU inputs
module sy_alu_opreg import sy_alu_pkg::*; #(
   parameter int WIDTH = SY_WIDTH,
   parameter int OPCW  = SY_OPCW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             inc_i,
   input  logic [OPCW-1:0]  opc_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             inc_o,
   output logic [OPCW-1:0]  opc_o
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             inc_q;
   logic [OPCW-1:0]  opc_q;

   // Values persist between operations; only an accepted ALU command reloads them.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         inc_q <= 1'b0;
         opc_q <= '0;
      end else if (en_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         inc_q <= inc_i;
         opc_q <= opc_i;
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign inc_o = inc_q;
   assign opc_o = opc_q;

endmodule

// File: rtl/sy_alu_ctrl.sv
// rtl/sy_alu_ctrl.sv - accumulator command sequencer around SY_ALU; SY_ALU_PIPE_EN adds an EXEC2 retiming stage
module sy_alu_ctrl import sy_alu_pkg::*; #(
   parameter int WIDTH = SY_WIDTH,
   parameter int OPCW  = SY_OPCW,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_ld,
   input  logic [OPCW-1:0]  cmd_opc,
   input  logic             cmd_inc,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] alu_inA,
   output logic [WIDTH-1:0] alu_inB,
   output logic             alu_inc,
   output logic [OPCW-1:0]  alu_opc,
   input  logic [WIDTH-1:0] alu_w,
   input  logic             alu_zer,
   input  logic             alu_neg,
   output logic [WIDTH-1:0] acc,
   output logic             zer_f,
   output logic             neg_f,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNTW-1:0]  op_cnt
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zer_q, zer_d;
   logic             neg_q, neg_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             opreg_en;

`ifdef SY_ALU_PIPE_EN
   logic [WIDTH-1:0] pw_q, pw_d;
   logic             pz_q, pz_d;
   logic             pn_q, pn_d;
`endif

   sy_alu_opreg #(.WIDTH(WIDTH), .OPCW(OPCW)) u_opreg (
      .clk   (clk),
      .rst   (rst),
      .en_i  (opreg_en),
      .a_i   (acc_q),
      .b_i   (cmd_data),
      .inc_i (cmd_inc),
      .opc_i (cmd_opc),
      .a_o   (alu_inA),
      .b_o   (alu_inB),
      .inc_o (alu_inc),
      .opc_o (alu_opc)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      zer_d     = zer_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      opreg_en  = 1'b0;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
`ifdef SY_ALU_PIPE_EN
      pw_d      = pw_q;
      pz_d      = pz_q;
      pn_d      = pn_q;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_ld) begin
                  acc_d   = cmd_data;
                  zer_d   = (cmd_data == '0);
                  neg_d   = cmd_data[WIDTH-1];
                  state_d = DONE;
               end else begin
                  opreg_en = 1'b1;
                  state_d  = EXEC;
               end
            end
         end
         EXEC: begin
`ifdef SY_ALU_PIPE_EN
            pw_d    = alu_w;
            pz_d    = alu_zer;
            pn_d    = alu_neg;
            state_d = EXEC2;
`else
            acc_d   = alu_w;
            zer_d   = alu_zer;
            neg_d   = alu_neg;
            cnt_d   = cnt_q + CNTW'(1);
            state_d = DONE;
`endif
         end
`ifdef SY_ALU_PIPE_EN
         EXEC2: begin
            acc_d   = pw_q;
            zer_d   = pz_q;
            neg_d   = pn_q;
            cnt_d   = cnt_q + CNTW'(1);
            state_d = DONE;
         end
`endif
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         zer_q   <= 1'b0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         zer_q   <= zer_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SY_ALU_PIPE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pw_q <= '0;
         pz_q <= 1'b0;
         pn_q <= 1'b0;
      end else begin
         pw_q <= pw_d;
         pz_q <= pz_d;
         pn_q <= pn_d;
      end
   end
`endif

   assign acc    = acc_q;
   assign zer_f  = zer_q;
   assign neg_f  = neg_q;
   assign op_cnt = cnt_q;

endmodule

// File: doc/sy_alu_ctrl.md
Name: sy_alu_ctrl

Overview:
- Accumulator-based command sequencer that sits directly upstream of SY_ALU and feeds it.
- Accepts commands over a valid/ready handshake and registers operands onto the ALU inputs (inA = accumulator, inB = command operand).
- Writes the ALU result w back into the accumulator, latches zer/neg, and presents the result over a second valid/ready handshake.
- Turns the combinational ALU into a sequential datapath.

Parameters:
- WIDTH, 16, datapath width; must match the SY_ALU 16-bit inA/inB/w.
- OPCW, 3, opcode width; must match the SY_ALU 3-bit opc.
- CNTW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_ld  in  1  1 = load cmd_data straight into the accumulator, no ALU op.
- cmd_opc  in  OPCW  ALU opcode.
- cmd_inc  in  1  ALU carry-in.
- cmd_data  in  WIDTH  operand B, or the load value.
- alu_inA  out  WIDTH  to SY_ALU inA (registered).
- alu_inB  out  WIDTH  to SY_ALU inB (registered).
- alu_inc  out  1  to SY_ALU inc (registered).
- alu_opc  out  OPCW  to SY_ALU opc (registered).
- alu_w  in  WIDTH  from SY_ALU w.
- alu_zer  in  1  from SY_ALU zer.
- alu_neg  in  1  from SY_ALU neg.
- acc  out  WIDTH  accumulator value.
- zer_f  out  1  latched zero flag.
- neg_f  out  1  latched negative flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- op_cnt  out  CNTW  count of completed ALU operations.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - acc, alu_inA, alu_inB, alu_inc, alu_opc, zer_f, neg_f, res_valid and op_cnt are all cleared to 0.
  - cmd_ready = 1 from the first cycle after reset.
  - Reset overrides everything, including mid-operation; an in-flight command is discarded.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready with cmd_ld = 0: register alu_inA <= acc, alu_inB <= cmd_data, alu_inc <= cmd_inc, alu_opc <= cmd_opc; go to EXEC.
  - On cmd_valid & cmd_ready with cmd_ld = 1: acc <= cmd_data, zer_f <= (cmd_data == 0), neg_f <= cmd_data[WIDTH-1]; go to DONE. op_cnt is unchanged.
- EXEC (one cycle; ALU settles combinationally):
  - cmd_ready = 0.
  - At the end of the cycle: acc <= alu_w, zer_f <= alu_zer, neg_f <= alu_neg, op_cnt <= op_cnt + 1; go to DONE.
- DONE:
  - res_valid = 1, cmd_ready = 0.
  - acc and the flags are held stable while res_valid = 1 and res_ready = 0.
  - On res_ready: go to IDLE. res_valid drops the following cycle.
- Latency: ALU op accepted at edge N gives res_valid high after edge N+2. A load gives res_valid high after edge N+1.
- Throughput:
  - ALU op: one every 3 cycles with res_ready tied high.
  - Load: one every 2 cycles with res_ready tied high.
- alu_* outputs hold their last value outside EXEC; they are not cleared on return to IDLE.
- op_cnt wraps from 2^CNTW-1 to 0 with no flag.
- cmd_valid during EXEC/DONE is ignored (not consumed). The sender must hold the command until cmd_ready.
- res_ready while not in DONE has no effect.

Optional Feature:
- SY_ALU_PIPE_EN defined:
  - Adds state EXEC2 between EXEC and DONE.
  - alu_w/alu_zer/alu_neg are sampled into an internal pipeline register at the end of EXEC, and written into acc/flags at the end of EXEC2.
  - ALU-op latency becomes N+3; load latency is unchanged.
  - Intended for a retimed ALU.
- Not defined: behaviour exactly as above, with no EXEC2 state.

Decomposition:
- Shared package sy_alu_pkg holds:
  - WIDTH/OPCW constants.
  - State enum: IDLE=2'd0, EXEC=2'd1, DONE=2'd2, EXEC2=2'd3.
- One natural sub-module: sy_alu_opreg, the operand/opcode register bank with a load enable.
- The FSM and accumulator stay in the top module.

Test Plan:
- Bench ALU model for opc 3'b000: w = inA + inB + inc; zer = (w == 0); neg = w[15]. SY_ALU is instantiated alongside as a cross-check.
- Reset then idle → acc = 0, zer_f = 0, neg_f = 0, res_valid = 0, cmd_ready = 1, op_cnt = 0.
- Load 16'h1234, then opc = 0, data = 16'h0001, inc = 1 → acc = 16'h1236, zer_f = 0, neg_f = 0, res_valid high 2 cycles after acceptance, op_cnt = 1.
- Load 16'hFFFF, then opc = 0, data = 16'h0001, inc = 0 → acc = 16'h0000, zer_f = 1. Then opc = 0, data = 16'h8000 → acc = 16'h8000, neg_f = 1.
- Hold res_ready = 0 for 5 cycles in DONE while driving cmd_valid → cmd_ready stays 0, acc stable, command not consumed. Raise res_ready → the command is accepted the cycle after return to IDLE.
- Assert rst during EXEC after loading 16'h00AA → all outputs 0 the next cycle, state IDLE, op_cnt = 0.
- 256 back-to-back opc = 0 ops with CNTW = 8 → op_cnt wraps to 0. With SY_ALU_PIPE_EN, each op shows res_valid 3 cycles after acceptance.
